// File: rtl/chaos_mixer_n_if.sv
// Stream bundle for chaos_mixer_n: sample-set input handshake and key-word output handshake.
// The master side drives samples and consumes words; the slave side is the mixer.
interface chaos_mixer_n_if #(
    parameter int W = 23,
    parameter int N = 3
);
    logic           in_valid;
    logic           in_ready;
    logic           mode;
    logic [N*W-1:0] ex;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [15:0]    word_cnt;

    modport master (
        output in_valid, mode, ex, out_ready,
        input  in_ready, out_valid, out_data, out_last, word_cnt
    );

    modport slave (
        input  in_valid, mode, ex, out_ready,
        output in_ready, out_valid, out_data, out_last, word_cnt
    );
endinterface

// File: rtl/chaos_mixer_n.sv
// Chaos mixer: conditions N chaotic channel samples, folds them by XOR or modular sum,
// and emits framed key words through a two-stage valid/ready pipeline.
module chaos_mixer_n #(
    parameter int         W         = 23,
    parameter int         N         = 3,
    parameter logic [7:0] MASK      = 8'hFF,
    parameter int         FRAME_LEN = 256
) (
    input logic             clk,
    input logic             rst,
    input logic             sclr,
    chaos_mixer_n_if.slave  bus
);
    localparam logic [W-1:0] MASK_W   = W'(MASK);
    localparam logic [15:0]  LAST_IDX = 16'(FRAME_LEN - 1);

    logic         s1_valid;
    logic         s1_mode;
    logic [W-1:0] s1_d [N];
    logic [W-1:0] d_in [N];
    logic [W-1:0] fold;
    logic         s2_adv;
    logic         accept;
    logic         out_valid_r;
    logic [W-1:0] out_data_r;
    logic [15:0]  word_cnt_r;

    always_comb begin
        d_in = '{default: '0};
        for (int unsigned i = 0; i < N; i++) begin
            d_in[i] = (bus.ex[i*W +: W] - (bus.ex[i*W +: W] ^ MASK_W)) & bus.ex[i*W +: W];
        end
    end

    always_comb begin
        fold = '0;
        for (int unsigned i = 0; i < N; i++) begin
            fold = s1_mode ? (fold + s1_d[i]) : (fold ^ s1_d[i]);
        end
    end

    // in_ready is gated by rst/sclr so nothing is accepted while the pipeline is being flushed
    assign s2_adv       = !out_valid_r || bus.out_ready;
    assign bus.in_ready = !rst && !sclr && (!s1_valid || s2_adv);
    assign accept       = bus.in_ready && bus.in_valid;

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.word_cnt  = word_cnt_r;
    assign bus.out_last  = out_valid_r && (word_cnt_r == LAST_IDX);

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_d    <= d_in;
            s1_mode <= bus.mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            word_cnt_r  <= '0;
        end else if (sclr) begin
            s1_valid    <= 1'b0;
            out_valid_r <= 1'b0;
            word_cnt_r  <= '0;
        end else begin
            if (out_valid_r && bus.out_ready) begin
                word_cnt_r <= (word_cnt_r == LAST_IDX) ? '0 : word_cnt_r + 16'd1;
            end
            if (s2_adv) begin
                out_valid_r <= s1_valid;
                if (s1_valid) begin
                    out_data_r <= fold;
                end
            end
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
        end
    end
endmodule

// File: tb/tb_chaos_mixer_n.sv
// Directed bench for chaos_mixer_n with a scoreboard queue fed on input acceptance
// and drained on output transfers.
module tb_chaos_mixer_n;
    localparam int         W  = 23;
    localparam int         N  = 3;
    localparam int         FL = 4;
    localparam logic [7:0] MK = 8'hFF;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic sclr = 1'b0;

    always #5 clk = ~clk;

    chaos_mixer_n_if #(.W(W), .N(N)) bus ();

    chaos_mixer_n #(.W(W), .N(N), .MASK(MK), .FRAME_LEN(FL)) dut (
        .clk  (clk),
        .rst  (rst),
        .sclr (sclr),
        .bus  (bus)
    );

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_q [$];
    int           exp_cnt     = 0;
    logic         stalled     = 1'b0;
    logic [W-1:0] held_data;
    logic [15:0]  held_cnt;
    logic         held_last;
    logic [W-1:0] popped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] cond(input logic [W-1:0] x);
        logic [31:0] wide;
        wide = {{(32-W){1'b0}}, x};
        wide = wide - (wide ^ {24'd0, MK});
        return W'(wide) & x;
    endfunction

    function automatic logic [W-1:0] model(input logic [N*W-1:0] e, input logic md);
        logic [31:0]  acc;
        logic [W-1:0] part;
        acc = '0;
        for (int c = 0; c < N; c++) begin
            part = cond(e[c*W +: W]);
            if (md) acc = acc + {{(32-W){1'b0}}, part};
            else    acc = acc ^ {{(32-W){1'b0}}, part};
        end
        return W'(acc);
    endfunction

    // Monitor: stall stability, ordered data, frame index and last flag
    always @(negedge clk) begin
        if (rst || sclr) begin
            exp_q.delete();
            exp_cnt = 0;
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(held_data));
                check("hold_cnt", 32'(bus.word_cnt), 32'(held_cnt));
                check("hold_last", 32'(bus.out_last), 32'(held_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    popped = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(popped));
                end
                check("word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
                check("out_last", 32'(bus.out_last), 32'(exp_cnt == FL - 1));
                exp_cnt = (exp_cnt + 1) % FL;
            end
            stalled   = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            held_cnt  = bus.word_cnt;
            held_last = bus.out_last;
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.ex, bus.mode));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] rnd_ex();
        return (N*W)'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic single(input string tag, input logic [N*W-1:0] e, input logic md,
                          input logic [W-1:0] expv);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.ex        = e;
        bus.mode      = md;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
        step();
        @(negedge clk);
        check({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(expv));
        step();
    endtask

    task automatic drain();
        int guard;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 50) begin
            step();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fill_two();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ex        = rnd_ex();
        bus.mode      = 1'b0;
        @(negedge clk);
        check("fill_rdy0", 32'(bus.in_ready), 32'd1);
        step();
        bus.ex   = rnd_ex();
        bus.mode = 1'b1;
        @(negedge clk);
        check("fill_rdy1", 32'(bus.in_ready), 32'd1);
        step();
        @(negedge clk);
        check("fill_full", 32'(bus.in_ready), 32'd0);
        check("fill_ov", 32'(bus.out_valid), 32'd1);
        step();
    endtask

    initial begin
        int k, guard;
        logic acc;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.ex        = '0;
        bus.out_ready = 1'b1;

        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        step();

        // Conditioning and both folds
        single("xor", {23'h00000F, 23'h000100, 23'h0000FF}, 1'b0, 23'h0001F0);
        single("sum", {23'h00000F, 23'h000100, 23'h0000FF}, 1'b1, 23'h00020E);
        single("zero", '0, 1'b1, 23'h000000);
        drain();

        // Backpressure with per-word random mode
        k = 0;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.ex       = rnd_ex();
        bus.mode     = 1'($urandom_range(0, 1));
        while (k < 8 && guard < 200) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus.in_ready;
            step();
            guard++;
            if (acc) begin
                k++;
                bus.ex   = rnd_ex();
                bus.mode = 1'($urandom_range(0, 1));
            end
        end
        check("bp_accepted", 32'(k), 32'd8);
        drain();

        // Pipeline full, then release with no bubble
        fill_two();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.ex   = rnd_ex();
            bus.mode = 1'(i);
            @(negedge clk);
            check("nobubble_ov", 32'(bus.out_valid), 32'd1);
            check("nobubble_rdy", 32'(bus.in_ready), 32'd1);
            step();
        end
        drain();

        // Synchronous clear with two words in flight
        fill_two();
        sclr         = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("sclr_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        sclr         = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sclr_out_valid", 32'(bus.out_valid), 32'd0);
        check("sclr_word_cnt", 32'(bus.word_cnt), 32'd0);
        step();

        // Framing across two wraps
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.ex   = rnd_ex();
            bus.mode = 1'(i >> 1);
            step();
        end
        drain();

        // Asynchronous reset pulse with a stalled word at a non-zero index
        fill_two();
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_word_cnt", 32'(bus.word_cnt), 32'd0);
        check("arst_out_data", 32'(bus.out_data), 32'd0);
        check("arst_out_last", 32'(bus.out_last), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        #4;
        rst = 1'b0;
        @(negedge clk);
        check("arst_rel_ready", 32'(bus.in_ready), 32'd1);
        step();
        single("after_rst", {23'h00000F, 23'h000100, 23'h0000FF}, 1'b0, 23'h0001F0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/chaos_mixer_n.md
CHAOS_MIXER_N -- requirements
Module: chaos_mixer_n

Interface
Parameters:
REQ-001 The block SHALL expose parameter W, default 23: bit width of each chaotic channel sample and of the output word.
REQ-002 The block SHALL expose parameter N, default 3, legal range 2..8: number of channels.
REQ-003 The block SHALL expose parameter MASK, default 8'hFF, zero-extended to W: conditioning mask.
REQ-004 The block SHALL expose parameter FRAME_LEN, default 256, legal range 2..65535: output words per frame.

Ports (name, direction, width, meaning):
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 sclr  input  1  synchronous clear: flushes the pipeline and the frame counter.
REQ-008 mode  input  1  fold select, sampled with each accepted input: 0 = XOR fold, 1 = modular-sum fold.
REQ-009 in_valid  input  1  the ex bus holds a valid sample set.
REQ-010 in_ready  output  1  the block accepts the sample set this cycle.
REQ-011 ex  input  N*W  packed channels; channel i occupies bits [i*W +: W].
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  the downstream consumer accepts out_data this cycle.
REQ-014 out_data  output  W  mixed key word.
REQ-015 out_last  output  1  high with the final word of each frame.
REQ-016 word_cnt  output  16  index of the word currently presented, 0..FRAME_LEN-1.

Function
REQ-017 Conditioning: for each channel, d_i SHALL equal ((ex_i - (ex_i ^ MASK)) & ex_i) mod 2^W, with two's-complement wrap on the subtraction.
REQ-018 Fold, mode 0: out word SHALL equal the XOR of d_0..d_{N-1}.
REQ-019 Fold, mode 1: out word SHALL equal (sum of d_0..d_{N-1}) mod 2^W.
REQ-020 The block SHALL be a two-stage pipeline.
  - Stage 1 registers all d_i, the captured mode and a valid bit.
  - Stage 2 registers the folded word, out_valid and out_last.
REQ-021 Latency SHALL be 2 cycles from input acceptance to out_valid when there is no stall.
REQ-022 Throughput SHALL be 1 word per cycle while out_ready is held high.
REQ-023 Handshake rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
REQ-024 Stall logic:
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv; in_ready is combinational, with no dependence on in_valid.
REQ-025 While out_valid && !out_ready, out_data, out_last and word_cnt SHALL hold stable, and no data SHALL be lost or duplicated.
REQ-026 Frame counter:
  - The counter SHALL increment on each output transfer.
  - It SHALL wrap from FRAME_LEN-1 to 0.
  - out_last SHALL equal (word_cnt == FRAME_LEN-1) && out_valid.
REQ-027 sclr SHALL dominate all other synchronous activity.
  - On the next edge: s1_valid = 0, out_valid = 0, word_cnt = 0.
  - in_ready SHALL be 0 during the sclr cycle.
  - Any transfer in that cycle is discarded.
REQ-028 Simultaneous events:
  - A new input accepted in the same cycle as an output transfer SHALL both proceed.
  - Mode SHALL be bound per word, so a mode change mid-stream affects only words accepted after the change.
REQ-029 Data registers need not be reset; valid bits and the counter SHALL be.

Reset
REQ-030 On rst assertion, the block SHALL immediately force s1_valid = 0, out_valid = 0, out_last = 0, word_cnt = 0 and out_data = 0, regardless of clk.
REQ-031 in_ready SHALL be 0 while rst is high and SHALL be 1 on the first cycle after release.
REQ-032 Reset mid-operation SHALL drop all in-flight words, and the first word after release SHALL report word_cnt = 0.

Verification (W=23, N=3, MASK=0xFF, FRAME_LEN=4)
REQ-033 Conditioning and XOR fold:
  - Stimulus: ex0=0x0000FF, ex1=0x000100, ex2=0x00000F, mode=0, out_ready=1.
  - Response: d = 0xFF, 0x100, 0xF; out_data = 0x0001F0 exactly 2 cycles later.
REQ-034 Sum fold:
  - Stimulus: the same ex values with mode=1.
  - Response: out_data = 0x00020E; all-zero channels give out_data = 0.
REQ-035 Backpressure:
  - Stimulus: stream 8 words with out_ready toggled pseudo-randomly.
  - Response: output order and values match the reference model, and held words are stable during stalls.
REQ-036 Framing:
  - Stimulus: 9 consecutive transfers.
  - Response: word_cnt = 0,1,2,3,0,1,2,3,0; out_last is high on transfers 4 and 8 only.
REQ-037 Pipeline full:
  - Stimulus: hold out_ready=0.
  - Response: in_ready falls to 0 after 2 accepted words. Asserting out_ready=1 and in_valid=1 together then yields 1 word/cycle with no bubble.
REQ-038 Clears:
  - Stimulus: assert sclr with 2 words in flight.
  - Response: out_valid=0 and word_cnt=0 next cycle.
  - Stimulus: async rst pulse between clock edges.
  - Response: outputs clear immediately, and the next frame restarts at word_cnt=0.
